// File: rtl/result_packer_pkg.sv
// Shared constants and types for the result packer: config register map and FSM states.
package result_packer_pkg;

  // Config register map shared by the layer pipeline blocks.
  localparam int CFG_LAYERS = 1;
  localparam int CFG_PACKER = 2;

  localparam int FRAME_LEN_W = 16;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

endpackage

// File: rtl/result_packer.sv
// Splits each wide layer result into GROUP_NB-lane beats on the image stream and
// marks the last beat of every frame of frame_len results.
module result_packer
  import result_packer_pkg::*;
#(
  parameter int CFG_DWIDTH = 32,
  parameter int CFG_AWIDTH = 5,
  parameter int DEPTH_NB   = 16,
  parameter int GROUP_NB   = 4,
  parameter int IMG_WIDTH  = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [CFG_DWIDTH-1:0]         cfg_data,
  input  logic [CFG_AWIDTH-1:0]         cfg_addr,
  input  logic                          cfg_valid,
  input  logic [IMG_WIDTH*DEPTH_NB-1:0] result,
  input  logic                          result_val,
  output logic                          result_rdy,
  output logic [GROUP_NB*IMG_WIDTH-1:0] str_data,
  output logic                          str_last,
  output logic                          str_val,
  input  logic                          str_rdy
);

  localparam int BEATS = DEPTH_NB / GROUP_NB;
  localparam int BW    = GROUP_NB * IMG_WIDTH;
  localparam int HW    = IMG_WIDTH * DEPTH_NB;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

  generate
    if ((GROUP_NB < 1) || (DEPTH_NB < GROUP_NB) || ((DEPTH_NB % GROUP_NB) != 0)) begin : g_bad_cfg
      $error("result_packer: DEPTH_NB must be a non-zero multiple of GROUP_NB");
    end
  endgenerate

  state_t                 state;
  state_t                 state_nxt;
  logic [CW-1:0]          beat_cnt;
  logic [CW-1:0]          next_beat;
  logic [HW-1:0]          hold;
  logic [FRAME_LEN_W-1:0] frame_len;
  logic [FRAME_LEN_W-1:0] frame_len_s;
  logic [FRAME_LEN_W-1:0] frame_cnt;
  logic [FRAME_LEN_W-1:0] cnt_base;
  logic [FRAME_LEN_W-1:0] eff_len;
  logic                   cur_last;
  logic                   final_hs;
  logic                   accept;
  logic                   is_last;
  logic                   cfg_hit;
  logic [31:0]            sel_base;
  logic                   unused_cfg_bits;

  assign unused_cfg_bits = ^cfg_data[CFG_DWIDTH-1:FRAME_LEN_W];

  // A frame that just closed on this cycle's final beat is counted as already wrapped,
  // so a result accepted in the same cycle starts the next frame.
  always_comb begin
    final_hs   = (state == SEND) && (beat_cnt == LAST_BEAT) && str_rdy;
    result_rdy = rst_n && ((state == IDLE) || final_hs);
    accept     = result_val && result_rdy;
    next_beat  = beat_cnt + 1'b1;
    sel_base   = 32'(next_beat) * 32'(BW);
    cnt_base   = (final_hs && cur_last) ? '0 : frame_cnt;
    eff_len    = (cnt_base == '0) ? frame_len : frame_len_s;
    is_last    = (({1'b0, cnt_base} + 17'd1) == {1'b0, eff_len});
    cfg_hit    = cfg_valid && (cfg_addr == CFG_AWIDTH'(CFG_PACKER));
    state_nxt  = state;
    if (accept) begin
      state_nxt = SEND;
    end else if (final_hs) begin
      state_nxt = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt    <= '0;
      hold        <= '0;
      frame_len   <= FRAME_LEN_W'(1);
      frame_len_s <= FRAME_LEN_W'(1);
      frame_cnt   <= '0;
      cur_last    <= 1'b0;
      str_data    <= '0;
      str_val     <= 1'b0;
      str_last    <= 1'b0;
    end else begin
      if (cfg_hit) begin
        frame_len <= (cfg_data[FRAME_LEN_W-1:0] == '0) ? FRAME_LEN_W'(1)
                                                       : cfg_data[FRAME_LEN_W-1:0];
      end
      frame_cnt <= accept ? (cnt_base + FRAME_LEN_W'(1)) : cnt_base;
      if (accept) begin
        hold     <= result;
        beat_cnt <= '0;
        cur_last <= is_last;
        if (cnt_base == '0) begin
          frame_len_s <= frame_len;
        end
        str_val  <= 1'b1;
        str_data <= result[BW-1:0];
        str_last <= (BEATS == 1) && is_last;
      end else if (final_hs) begin
        str_val  <= 1'b0;
        str_last <= 1'b0;
      end else if (str_val && str_rdy) begin
        beat_cnt <= next_beat;
        str_data <= hold[sel_base +: BW];
        str_last <= (next_beat == LAST_BEAT) && cur_last;
      end
    end
  end

endmodule

// File: tb/tb_result_packer.sv
// Self-checking bench for result_packer: a queue-based frame/beat model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_result_packer;
  import result_packer_pkg::*;

  localparam int DEPTH = 16;
  localparam int GROUP = 4;
  localparam int IMGW  = 16;
  localparam int NBEAT = DEPTH / GROUP;
  localparam int BW    = GROUP * IMGW;
  localparam int HW    = DEPTH * IMGW;

  typedef struct {
    logic [BW-1:0] data;
    logic          last;
  } beat_t;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [31:0]     cfg_data;
  logic [4:0]      cfg_addr;
  logic            cfg_valid;
  logic [HW-1:0]   result;
  logic            result_val;
  logic            result_rdy;
  logic [BW-1:0]   str_data;
  logic            str_last;
  logic            str_val;
  logic            str_rdy;

  int checks   = 0;
  int failures = 0;
  int cycle    = 0;
  int rdy_mode = 0;
  int phase    = 0;

  beat_t         q[$];
  logic [BW-1:0] log_data[$];
  logic          log_last[$];
  int            log_cyc[$];
  int            m_len = 1;
  int            m_len_s = 1;
  int            m_cnt = 0;
  logic          stall_prev = 1'b0;
  logic [BW-1:0] prev_data;
  logic          prev_last;

  result_packer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_data   (cfg_data),
    .cfg_addr   (cfg_addr),
    .cfg_valid  (cfg_valid),
    .result     (result),
    .result_val (result_val),
    .result_rdy (result_rdy),
    .str_data   (str_data),
    .str_last   (str_last),
    .str_val    (str_val),
    .str_rdy    (str_rdy)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    failures++;
    $display("[TB] FAIL %s actual=timeout expected=handshake (cycle %0d)", name, cycle);
  endtask

  function automatic logic [HW-1:0] make_word(input int base);
    logic [HW-1:0] w;
    w = '0;
    for (int i = 0; i < DEPTH; i++) w[i*IMGW +: IMGW] = IMGW'(base + i);
    return w;
  endfunction

  // Reference model: each accepted result becomes NBEAT queued beats; the frame rule
  // decides which result carries the last flag.
  task automatic model_accept(input logic [HW-1:0] w);
    logic lastf;
    if (m_cnt == 0) m_len_s = (m_len == 0) ? 1 : m_len;
    m_cnt++;
    lastf = (m_cnt == m_len_s);
    if (lastf) m_cnt = 0;
    for (int b = 0; b < NBEAT; b++) q.push_back('{data: w[b*BW +: BW], last: lastf && (b == NBEAT - 1)});
  endtask

  always @(negedge clk) begin
    logic exp_val;
    logic exp_rdy;
    if (!rst_n) begin
      check("rst_str_val", BW'(str_val), 0);
      check("rst_str_last", BW'(str_last), 0);
      check("rst_str_data", str_data, 0);
      check("rst_result_rdy", BW'(result_rdy), 0);
      q.delete();
      m_len = 1;
      m_len_s = 1;
      m_cnt = 0;
      stall_prev = 1'b0;
    end else begin
      exp_val = (q.size() != 0);
      exp_rdy = (q.size() == 0) || ((q.size() == 1) && str_rdy);
      check("str_val", BW'(str_val), BW'(exp_val));
      check("result_rdy", BW'(result_rdy), BW'(exp_rdy));
      if (str_val && q.size() != 0) begin
        check("str_data", str_data, q[0].data);
        check("str_last", BW'(str_last), BW'(q[0].last));
      end
      if (stall_prev) begin
        check("stall_val", BW'(str_val), 1);
        check("stall_data", str_data, prev_data);
        check("stall_last", BW'(str_last), BW'(prev_last));
      end
      if (str_val && str_rdy) begin
        log_data.push_back(str_data);
        log_last.push_back(str_last);
        log_cyc.push_back(cycle);
        if (q.size() != 0) void'(q.pop_front());
      end
      stall_prev = str_val && !str_rdy;
      prev_data  = str_data;
      prev_last  = str_last;
      if (result_val && exp_rdy) model_accept(result);
      if (cfg_valid && cfg_addr == 5'(CFG_PACKER)) m_len = int'(cfg_data[15:0]);
    end
  end

  initial begin
    str_rdy = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (rdy_mode == 0) str_rdy = 1'b1;
      else begin
        logic [2:0] pat;
        pat = 3'b001;
        str_rdy = pat[phase % 3];
        phase++;
      end
    end
  end

  task automatic write_cfg(input int len);
    cfg_addr  = 5'(CFG_PACKER);
    cfg_data  = 32'(len);
    cfg_valid = 1'b1;
    @(posedge clk);
    #1;
    cfg_valid = 1'b0;
  endtask

  task automatic send_result(input logic [HW-1:0] w);
    logic got;
    result     = w;
    result_val = 1'b1;
    got = 1'b0;
    for (int n = 0; n < 200 && !got; n++) begin
      @(negedge clk);
      got = result_rdy;
    end
    if (!got) timeout_fail("send_timeout");
    @(posedge clk);
    #1;
    result_val = 1'b0;
  endtask

  task automatic wait_idle();
    logic got;
    got = 1'b0;
    for (int n = 0; n < 400 && !got; n++) begin
      @(negedge clk);
      got = !str_val;
    end
    if (!got) timeout_fail("idle_timeout");
    @(posedge clk);
    #1;
  endtask

  task automatic check_lasts(input string name, input int b, input int n, input int every);
    check({name, "_count"}, BW'(log_data.size() - b), BW'(n));
    for (int i = 0; i < n && (b + i) < log_last.size(); i++)
      check({name, "_last"}, BW'(log_last[b+i]), BW'(((i + 1) % every) == 0));
  endtask

  initial begin
    logic [BW-1:0] exp_t1 [4];
    int b;
    int n;
    exp_t1 = '{64'h0003_0002_0001_0000, 64'h0007_0006_0005_0004,
               64'h000b_000a_0009_0008, 64'h000f_000e_000d_000c};
    rst_n = 1'b1;
    cfg_valid = 1'b0;
    cfg_addr = '0;
    cfg_data = '0;
    result = '0;
    result_val = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("reset_val", BW'(str_val), 0);
    check("reset_rdy", BW'(result_rdy), 0);
    check("reset_data", str_data, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Single result, frame_len from reset (1)
    b = log_data.size();
    send_result(make_word(0));
    wait_idle();
    check_lasts("t1", b, 4, 4);
    for (int i = 0; i < 4 && (b + i) < log_data.size(); i++) begin
      check("t1_data", log_data[b+i], exp_t1[i]);
      check("t1_cyc", BW'(log_cyc[b+i] - log_cyc[b]), BW'(i));
    end

    // Back-to-back, frame_len=2
    write_cfg(2);
    b = log_data.size();
    send_result(make_word(16'h100));
    send_result(make_word(16'h200));
    wait_idle();
    check_lasts("t2", b, 8, 8);
    for (int i = 1; i < 8 && (b + i) < log_cyc.size(); i++)
      check("t2_gap", BW'(log_cyc[b+i] - log_cyc[b+i-1]), 1);
    if (b + 4 < log_data.size()) check("t2_beat4", log_data[b+4], 64'h0203_0202_0201_0200);

    // Backpressure 1,0,0 with frame_len=1
    write_cfg(1);
    rdy_mode = 1;
    b = log_data.size();
    send_result(make_word(16'h10));
    send_result(make_word(16'h20));
    wait_idle();
    rdy_mode = 0;
    check_lasts("t3", b, 8, 4);
    if (b + 3 < log_data.size()) begin
      check("t3_b0", log_data[b],   64'h0013_0012_0011_0010);
      check("t3_b1", log_data[b+1], 64'h0017_0016_0015_0014);
      check("t3_b2", log_data[b+2], 64'h001b_001a_0019_0018);
      check("t3_b3", log_data[b+3], 64'h001f_001e_001d_001c);
    end

    // Mid-frame cfg change: frame of 3, then frames of 1
    write_cfg(3);
    b = log_data.size();
    send_result(make_word(16'h300));
    write_cfg(1);
    for (int r = 1; r < 5; r++) send_result(make_word(16'h300 + r * 16'h10));
    wait_idle();
    check("t4_count", BW'(log_data.size() - b), 20);
    for (int i = 0; i < 20 && (b + i) < log_last.size(); i++)
      check("t4_last", BW'(log_last[b+i]), BW'(i == 11 || i == 15 || i == 19));

    // Reset during beat 2 of a partial frame
    write_cfg(3);
    b = log_data.size();
    send_result(make_word(16'h400));
    n = 0;
    while (log_data.size() < b + 2 && n < 100) begin
      @(posedge clk);
      n++;
    end
    if (n >= 100) timeout_fail("t5_wait_beat2");
    #2 rst_n = 1'b0;
    #1;
    check("t5_val_async", BW'(str_val), 0);
    check("t5_data_async", str_data, 0);
    check("t5_rdy_async", BW'(result_rdy), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    write_cfg(2);
    b = log_data.size();
    send_result(make_word(16'h500));
    send_result(make_word(16'h600));
    wait_idle();
    check_lasts("t5", b, 8, 8);
    if (b < log_data.size()) check("t5_b0", log_data[b], 64'h0503_0502_0501_0500);

    // frame_len=0 behaves as 1
    write_cfg(0);
    b = log_data.size();
    send_result(make_word(16'h700));
    send_result(make_word(16'h800));
    wait_idle();
    check_lasts("t6", b, 8, 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=running expected=finished");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/result_packer.md
RESULT_PACKER -- requirements
Module: result_packer

Interface
REQ-001 Parameters SHALL be:
- CFG_DWIDTH, default 32, config data width.
- CFG_AWIDTH, default 5, config address width.
- DEPTH_NB, default 16, result lanes per wide word.
- GROUP_NB, default 4, lanes per output beat.
- IMG_WIDTH, default 16, bits per lane.
REQ-002 Clocking SHALL be one clock; reset is asynchronous and active-low.
REQ-003 Ports SHALL be:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- cfg_data  in  CFG_DWIDTH  config write data.
- cfg_addr  in  CFG_AWIDTH  config write address.
- cfg_valid  in  1  config write strobe.
- result  in  IMG_WIDTH*DEPTH_NB  wide result word from the layer pipeline.
- result_val  in  1  result valid; held until accepted.
- result_rdy  out  1  packer can accept a result.
- str_data  out  GROUP_NB*IMG_WIDTH  output beat, image-bus width.
- str_last  out  1  final beat of a frame.
- str_val  out  1  beat valid.
- str_rdy  in  1  downstream accepts the beat.

Function
REQ-004 BEATS SHALL equal DEPTH_NB/GROUP_NB, and DEPTH_NB SHALL be an integer multiple of GROUP_NB; otherwise elaboration fails.
REQ-005 A cfg write with cfg_valid=1 and cfg_addr==CFG_PACKER SHALL load frame_len from cfg_data[15:0]; frame_len==0 SHALL be treated as 1.
REQ-006 The FSM SHALL have two states, IDLE and SEND; reset state is IDLE.
REQ-007 In IDLE, result_rdy SHALL be 1; result_val=1 accepts the result into the hold buffer, clears beat_cnt, and moves to SEND.
REQ-008 In SEND, str_val SHALL be 1 and str_data SHALL equal hold[beat_cnt*GROUP_NB*IMG_WIDTH +: GROUP_NB*IMG_WIDTH], lowest lanes first.
REQ-009 On str_val&str_rdy with beat_cnt<BEATS-1, beat_cnt SHALL increment.
REQ-010 On the final beat (beat_cnt==BEATS-1) with str_rdy=1, the block SHALL return to IDLE; if result_val=1 in that same cycle, it SHALL instead accept the new result and remain in SEND with beat_cnt=0, with no bubble.
REQ-011 result_rdy SHALL be 1 in IDLE, or in SEND on the final beat when str_rdy=1; 0 otherwise.
REQ-012 str_data, str_val and str_last SHALL be registered and SHALL hold stable while str_val=1 and str_rdy=0.
REQ-013 Latency: a result accepted at edge N SHALL present beat 0 with str_val=1 after edge N; BEATS consecutive beats follow under continuous str_rdy.
REQ-014 frame_cnt SHALL count accepted results, and str_last SHALL be 1 only on the final beat of result number frame_len_s. After that beat is accepted, frame_cnt SHALL wrap to 0.
REQ-015 frame_len_s SHALL be a shadow of frame_len latched when frame_cnt==0 and a result is accepted; a cfg write mid-frame takes effect at the next frame.
REQ-016 Simultaneous cfg write and result accept at frame start SHALL latch the old frame_len value.
REQ-017 The block SHALL never drop or duplicate a beat under any str_rdy pattern.

Reset
REQ-018 While rst_n=0, the following SHALL hold: state=IDLE, str_val=0, str_last=0, str_data=0, beat_cnt=0, frame_cnt=0, frame_len=1, result_rdy=0.
REQ-019 Reset asserted mid-frame SHALL discard the hold buffer and any partial frame immediately and asynchronously; the first result after release starts a new frame.

Structure
REQ-020 The CFG_PACKER address SHALL be added to the shared cfg_parameters.vh alongside CFG_LAYERS; no other shared constants are required.
REQ-021 The block SHALL be a single module with no sub-module; beat select, counters and FSM are local.

Verification
REQ-022 With defaults (4 beats) and frame_len=1: one result with lanes 0..15 holding values 0x0000..0x000F, str_rdy=1 -> 4 beats {3,2,1,0},{7,6,5,4},{B,A,9,8},{F,E,D,C} on consecutive cycles, str_last on beat 3 only.
REQ-023 Back-to-back: frame_len=2, two results offered continuously, str_rdy=1 -> 8 consecutive beats with no gap, result_rdy pulses exactly on beat 3, str_last only on beat 7.
REQ-024 Backpressure: str_rdy toggling 1,0,0,1,... -> str_data/str_val stable during stalls, all 4 beats emitted in order, no result accepted before the final-beat handshake.
REQ-025 Mid-frame cfg: frame_len=3, write frame_len=1 after the first result -> str_last on result 3; the following frame asserts str_last after every result.
REQ-026 Reset mid-frame: rst_n=0 during beat 2 -> str_val=0 immediately; after release, a new result yields beat 0 with frame counting restarted (str_last on result frame_len).
REQ-027 frame_len=0 -> behaves as 1; str_last asserted on every result's beat 3.
